// File: rtl/riscv_pkg.sv
// Shared widths and ALU operation codes for the integer pipeline.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_CTRL_W = 3;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SRA = 3'b010,
    ALU_SLL = 3'b011,
    ALU_SRL = 3'b100,
    ALU_AND = 3'b101,
    ALU_XOR = 3'b110
  } alu_ctrl_e;

  // A result bus hits a source operand only if it writes, the index matches,
  // and the index is not x0 (x0 is hardwired and must never be replaced).
  function automatic logic addr_hit(
    input logic                  we,
    input logic [REG_ADDR_W-1:0] bus_rd,
    input logic [REG_ADDR_W-1:0] src
  );
    return we && (bus_rd == src) && (src != '0);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: EX/MEM result beats writeback result,
// which beats the value held in the ID/EX register.
module fwd_mux
  import riscv_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_src_addr,
  input  logic [XLEN-1:0]       i_stored_val,
  input  logic                  i_exm_reg_write,
  input  logic [REG_ADDR_W-1:0] i_exm_rd,
  input  logic [XLEN-1:0]       i_exm_result,
  input  logic                  i_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0]       i_wb_result,
  output logic [XLEN-1:0]       o_sel_val
);

  // Priority select, fully combinational.
  always_comb begin
    o_sel_val = i_stored_val;
    if (addr_hit(i_exm_reg_write, i_exm_rd, i_src_addr)) begin
      o_sel_val = i_exm_result;
    end else if (addr_hit(i_wb_reg_write, i_wb_rd, i_src_addr)) begin
      o_sel_val = i_wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single-entry valid/ready stage with flush,
// operand forwarding and writeback snooping of held operands.
// Build option: define ID_EX_FWD_EN to enable forwarding and snooping;
// without it operands come only from the values captured at accept.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       imm,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [ALU_CTRL_W-1:0] alu_sel,
  input  logic                  use_imm,
  input  logic                  is_branch,
  input  logic                  reg_write,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  exm_reg_write,
  input  logic [XLEN-1:0]       exm_result,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  reg_write_out,
  output logic                  is_branch_out
);

  logic                  r_valid;
  logic [XLEN-1:0]       r_rs1_val;
  logic [XLEN-1:0]       r_rs2_val;
  logic [XLEN-1:0]       r_imm;
  logic [REG_ADDR_W-1:0] r_rs1_addr;
  logic [REG_ADDR_W-1:0] r_rs2_addr;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [ALU_CTRL_W-1:0] r_alu_ctrl;
  logic                  r_use_imm;
  logic                  r_is_branch;
  logic                  r_reg_write;

  logic                  w_accept;
  logic [XLEN-1:0]       w_rs1_cap;
  logic [XLEN-1:0]       w_rs2_cap;
  logic [XLEN-1:0]       w_rs1_hold;
  logic [XLEN-1:0]       w_rs2_hold;
  logic [XLEN-1:0]       w_rs1_sel;
  logic [XLEN-1:0]       w_rs2_sel;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

`ifdef ID_EX_FWD_EN
  // A writeback landing on the accept edge or while the entry waits would
  // otherwise be lost, since the register file read already happened.
  assign w_rs1_cap  = addr_hit(wb_reg_write, wb_rd, rs1_addr)   ? wb_result : rs1_data;
  assign w_rs2_cap  = addr_hit(wb_reg_write, wb_rd, rs2_addr)   ? wb_result : rs2_data;
  assign w_rs1_hold = addr_hit(wb_reg_write, wb_rd, r_rs1_addr) ? wb_result : r_rs1_val;
  assign w_rs2_hold = addr_hit(wb_reg_write, wb_rd, r_rs2_addr) ? wb_result : r_rs2_val;

  fwd_mux u_fwd_rs1 (
    .i_src_addr      (r_rs1_addr),
    .i_stored_val    (r_rs1_val),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_rd        (exm_rd),
    .i_exm_result    (exm_result),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_rd         (wb_rd),
    .i_wb_result     (wb_result),
    .o_sel_val       (w_rs1_sel)
  );

  fwd_mux u_fwd_rs2 (
    .i_src_addr      (r_rs2_addr),
    .i_stored_val    (r_rs2_val),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_rd        (exm_rd),
    .i_exm_result    (exm_result),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_rd         (wb_rd),
    .i_wb_result     (wb_result),
    .o_sel_val       (w_rs2_sel)
  );
`else
  logic w_unused_fwd;

  assign w_rs1_cap  = rs1_data;
  assign w_rs2_cap  = rs2_data;
  assign w_rs1_hold = r_rs1_val;
  assign w_rs2_hold = r_rs2_val;
  assign w_rs1_sel  = r_rs1_val;
  assign w_rs2_sel  = r_rs2_val;
  // Forwarding buses and stored indices stay on the interface but go nowhere.
  assign w_unused_fwd = ^{exm_rd, exm_reg_write, exm_result,
                          wb_rd, wb_reg_write, wb_result,
                          r_rs1_addr, r_rs2_addr};
`endif

  // Entry occupancy: flush wins, then accept, then drain on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Field capture on accept; held operand values track writeback snoops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd        <= '0;
      r_alu_ctrl  <= ALU_ADD;
      r_use_imm   <= 1'b0;
      r_is_branch <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (w_accept) begin
      r_rs1_val   <= w_rs1_cap;
      r_rs2_val   <= w_rs2_cap;
      r_imm       <= imm;
      r_rs1_addr  <= rs1_addr;
      r_rs2_addr  <= rs2_addr;
      r_rd        <= rd_addr;
      r_alu_ctrl  <= alu_sel;
      r_use_imm   <= use_imm;
      r_is_branch <= is_branch;
      r_reg_write <= reg_write;
    end else if (r_valid) begin
      r_rs1_val   <= w_rs1_hold;
      r_rs2_val   <= w_rs2_hold;
    end
  end

  assign out_valid     = r_valid;
  assign alu_a         = w_rs1_sel;
  assign alu_b         = r_use_imm ? r_imm : w_rs2_sel;
  assign alu_control   = r_alu_ctrl;
  assign rd_out        = r_rd;
  assign reg_write_out = r_valid && r_reg_write;
  assign is_branch_out = r_valid && r_is_branch;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 in_valid  in  1  decode presents an instruction; in_ready  out  1  stage can accept.
REQ-004 rs1_data, rs2_data, imm  in  32 each  register-file operands and sign-extended immediate.
REQ-005 rs1_addr, rs2_addr, rd_addr  in  5 each  source/destination register indices.
REQ-006 alu_sel  in  3  ALU op code (000 add, 001 sub, 010 sra, 011 sll, 100 srl, 101 and, 110 xor).
REQ-007 use_imm, is_branch, reg_write  in  1 each  decoded control bits.
REQ-008 flush  in  1  discard held and incoming instruction.
REQ-009 exm_rd  in  5; exm_reg_write  in  1; exm_result  in  32  EX/MEM forwarding bus.
REQ-010 wb_rd  in  5; wb_reg_write  in  1; wb_result  in  32  writeback forwarding bus.
REQ-011 out_valid  out  1; out_ready  in  1  handshake toward the ALU stage.
REQ-012 alu_a, alu_b  out  32; alu_control  out  3; rd_out  out  5; reg_write_out, is_branch_out  out  1 each.

Function
REQ-013 Single-entry pipeline register; in_ready SHALL equal (!out_valid || out_ready) and be combinational.
REQ-014 Accept occurs when in_valid && in_ready && !flush; fields captured on that edge; out_valid asserted next cycle (latency 1).
REQ-015 out_valid SHALL clear on an edge where out_ready is high and no accept occurs; accept with out_ready high SHALL replace entry without a bubble.
REQ-016 flush high SHALL clear out_valid at the next edge and block accept that cycle, regardless of in_valid/out_ready.
REQ-017 While out_valid && !out_ready, all outputs SHALL hold stable except operand values updated per REQ-019.
REQ-018 Operand select, per source, priority: exm match (exm_reg_write && exm_rd==src && src!=0) > wb match (same rule) > stored value; combinational to alu_a/alu_b.
REQ-019 Snoop: while holding, stored rs1/rs2 value SHALL be overwritten by wb_result when wb_reg_write && wb_rd==addr && addr!=0; same on accept edge (captured value replaced).
REQ-020 alu_a = selected rs1 value; alu_b = imm when use_imm, else selected rs2 value.
REQ-021 Register 0 SHALL never be forwarded or snooped; its operand is the stored value.
REQ-022 alu_control, rd_out, reg_write_out, is_branch_out SHALL be captured fields; reg_write_out and is_branch_out SHALL be forced 0 when out_valid is 0.

Reset
REQ-023 rst_n low SHALL immediately clear out_valid and all stored fields to 0; alu_control resets to 000 (add).
REQ-024 Reset assertion mid-handshake SHALL drop the held instruction; first accept allowed on first edge after rst_n deasserts.

Configuration
REQ-025 Macro ID_EX_FWD_EN defined: REQ-018 and REQ-019 active.
REQ-026 ID_EX_FWD_EN undefined: forwarding and snoop logic omitted, exm_*/wb_* ports present but ignored, operands come only from captured values.

Structure
REQ-027 Shared package riscv_pkg SHALL hold XLEN=32, REG_ADDR_W=5, ALU_CTRL_W=3 and named alu_control codes.
REQ-028 One sub-module fwd_mux (one instance per source operand) SHALL implement the REQ-018 priority select.

Verification
REQ-029 Accept rs1_data=5, imm=7, use_imm=1, alu_sel=000, out_ready=1 -> next cycle out_valid=1, alu_a=5, alu_b=7, alu_control=000.
REQ-030 Held entry rs1_addr=3, exm_rd=3, exm_reg_write=1, exm_result=0xAA, wb_rd=3, wb_result=0xBB -> alu_a=0xAA (FWD_EN), stored value otherwise.
REQ-031 rs2_addr=0, exm_rd=0, exm_reg_write=1, exm_result=0xFF -> alu_b keeps stored 0, no forward.
REQ-032 out_ready=0 for 3 cycles, wb writes rd=4 value 0x1234 matching rs2_addr=4 -> after stall alu_b=0x1234 with no wb bus active.
REQ-033 flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0, reg_write_out=0, new instruction not captured.
REQ-034 rst_n pulsed low mid-stall -> out_valid=0 and alu_control=000 immediately, without a clock edge.
